// File: rtl/iob_cache_fe_arbiter.sv
// Round-robin arbiter sharing one cache IOb front-end between N_REQ managers.
// An in-order ID FIFO steers each read response back to its issuing manager.
module iob_cache_fe_arbiter #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PEND_W = 2
) (
    input  logic                      clk_i,
    input  logic                      cke_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          s_iob_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]   s_iob_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   s_iob_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0] s_iob_wstrb_i,
    output logic [N_REQ-1:0]          s_iob_ready_o,
    output logic [N_REQ-1:0]          s_iob_rvalid_o,
    output logic [N_REQ*DATA_W-1:0]   s_iob_rdata_o,
    output logic                      iob_valid_o,
    output logic [ADDR_W-1:0]         iob_addr_o,
    output logic [DATA_W-1:0]         iob_wdata_o,
    output logic [DATA_W/8-1:0]       iob_wstrb_o,
    input  logic                      iob_ready_i,
    input  logic                      iob_rvalid_i,
    input  logic [DATA_W-1:0]         iob_rdata_i
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned DEPTH  = 2 ** PEND_W;
    localparam int unsigned CNT_W  = PEND_W + 1;

    logic [IDX_W-1:0]  r_ptr;
    logic              r_lock;
    logic [IDX_W-1:0]  r_lidx;
    logic [IDX_W-1:0]  r_fifo [DEPTH];
    logic [PEND_W-1:0] r_wptr;
    logic [PEND_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_found;
    logic [IDX_W-1:0]  w_g;
    logic [IDX_W-1:0]  w_g_next;
    logic [STRB_W-1:0] w_sel_wstrb;
    logic              w_is_read;
    logic              w_block;
    logic              w_acc;
    logic              w_push;
    logic              w_pop;
    int unsigned       w_j;

    // Grant: locked index holds, otherwise first valid searching from r_ptr
    always_comb begin
        w_found = 1'b0;
        w_g     = r_ptr;
        w_j     = 0;
        if (r_lock) begin
            w_found = 1'b1;
            w_g     = r_lidx;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                w_j = (32'(r_ptr) + i) % N_REQ;
                if (!w_found && s_iob_valid_i[w_j]) begin
                    w_found = 1'b1;
                    w_g     = IDX_W'(w_j);
                end
            end
        end
    end

    assign w_g_next    = (w_g == IDX_W'(N_REQ - 1)) ? '0 : w_g + IDX_W'(1);
    assign w_sel_wstrb = s_iob_wstrb_i[32'(w_g) * STRB_W +: STRB_W];
    assign w_is_read   = (w_sel_wstrb == '0);
    // Only reads stall on a full ID FIFO; writes never produce a response
    assign w_block     = w_is_read && (r_cnt == CNT_W'(DEPTH));

    assign iob_valid_o = !rst_i && w_found && s_iob_valid_i[w_g] && !w_block;
    assign iob_addr_o  = s_iob_addr_i[32'(w_g) * ADDR_W +: ADDR_W];
    assign iob_wdata_o = s_iob_wdata_i[32'(w_g) * DATA_W +: DATA_W];
    assign iob_wstrb_o = w_sel_wstrb;

    assign w_acc  = iob_valid_o && iob_ready_i;
    assign w_push = w_acc && w_is_read;
    // A response with nothing outstanding is a protocol error and is dropped
    assign w_pop  = !rst_i && iob_rvalid_i && (r_cnt != '0);

    always_comb begin
        s_iob_ready_o = '0;
        if (!rst_i && w_found) begin
            s_iob_ready_o[w_g] = iob_ready_i && !w_block;
        end
    end

    always_comb begin
        s_iob_rvalid_o = '0;
        if (w_pop) begin
            s_iob_rvalid_o[r_fifo[r_rptr]] = 1'b1;
        end
    end

    assign s_iob_rdata_o = {N_REQ{iob_rdata_i}};

    // Arbitration state and FIFO bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr  <= '0;
            r_lock <= 1'b0;
            r_lidx <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (cke_i) begin
            if (w_acc) begin
                r_ptr  <= w_g_next;
                r_lock <= 1'b0;
            end else if (iob_valid_o) begin
                r_lock <= 1'b1;
                r_lidx <= w_g;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PEND_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PEND_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // ID storage needs no reset; occupancy gates every read of it
    always_ff @(posedge clk_i) begin
        if (!rst_i && cke_i && w_push) begin
            r_fifo[r_wptr] <= w_g;
        end
    end

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// Cycle-by-cycle vector table for iob_cache_fe_arbiter (N_REQ=2, PEND_W=2),
// with a response scoreboard that tracks which manager each read belongs to.
module tb_iob_cache_fe_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic              clk_i = 1'b0;
    logic              cke_i;
    logic              rst_i;
    logic [N-1:0]      s_iob_valid_i;
    logic [N*AW-1:0]   s_iob_addr_i;
    logic [N*DW-1:0]   s_iob_wdata_i;
    logic [N*SW-1:0]   s_iob_wstrb_i;
    logic [N-1:0]      s_iob_ready_o;
    logic [N-1:0]      s_iob_rvalid_o;
    logic [N*DW-1:0]   s_iob_rdata_o;
    logic              iob_valid_o;
    logic [AW-1:0]     iob_addr_o;
    logic [DW-1:0]     iob_wdata_o;
    logic [SW-1:0]     iob_wstrb_o;
    logic              iob_ready_i;
    logic              iob_rvalid_i;
    logic [DW-1:0]     iob_rdata_i;

    iob_cache_fe_arbiter dut (
        .clk_i          (clk_i),
        .cke_i          (cke_i),
        .rst_i          (rst_i),
        .s_iob_valid_i  (s_iob_valid_i),
        .s_iob_addr_i   (s_iob_addr_i),
        .s_iob_wdata_i  (s_iob_wdata_i),
        .s_iob_wstrb_i  (s_iob_wstrb_i),
        .s_iob_ready_o  (s_iob_ready_o),
        .s_iob_rvalid_o (s_iob_rvalid_o),
        .s_iob_rdata_o  (s_iob_rdata_o),
        .iob_valid_o    (iob_valid_o),
        .iob_addr_o     (iob_addr_o),
        .iob_wdata_o    (iob_wdata_o),
        .iob_wstrb_o    (iob_wstrb_o),
        .iob_ready_i    (iob_ready_i),
        .iob_rvalid_i   (iob_rvalid_i),
        .iob_rdata_i    (iob_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        cke;
        logic [1:0]  v;
        logic [1:0]  wr;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ev;
        logic [31:0] ea;
        logic [1:0]  er;
        logic [1:0]  erv;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   sb[$];

    function automatic vec_t mk(input logic rst, input logic cke, input logic [1:0] v,
                                input logic [1:0] wr, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic ev, input logic [31:0] ea,
                                input logic [1:0] er, input logic [1:0] erv);
        vec_t t;
        t.rst = rst; t.cke = cke; t.v = v; t.wr = wr; t.rdy = rdy; t.rv = rv;
        t.rd = rd; t.ev = ev; t.ea = ea; t.er = er; t.erv = erv;
        return t;
    endfunction

    task automatic chk(input int row, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL row%0d %s: got %h want %h", row, name, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int k);
        return (k == 0) ? 32'h10 : 32'h20;
    endfunction

    initial begin
        //              rst cke v      wr     rdy rv  rd            ev  ea      er     erv
        // single read, then a stray response that must be dropped
        vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 1, 0, 32'h0,        0, 32'h0,  2'b00, 2'b00));
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 32'hDEADBEEF, 0, 32'h0,  2'b00, 2'b01));
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 32'h5555,     0, 32'h0,  2'b00, 2'b00));
        // reset forces handshake outputs low
        vecs.push_back(mk(1, 1, 2'b11, 2'b00, 1, 1, 32'h7,        0, 32'h0,  2'b00, 2'b00));
        // fairness with both writing
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 1, 2'b11, 2'b11, 1, 0, 32'h0, 1, addr_of(i % 2),
                              (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00));
        // lock on s1 for 3 stalled cycles
        vecs.push_back(mk(0, 1, 2'b10, 2'b11, 0, 0, 32'h0,        1, 32'h20, 2'b00, 2'b00));
        vecs.push_back(mk(0, 1, 2'b11, 2'b11, 0, 0, 32'h0,        1, 32'h20, 2'b00, 2'b00));
        vecs.push_back(mk(0, 1, 2'b11, 2'b11, 0, 0, 32'h0,        1, 32'h20, 2'b00, 2'b00));
        vecs.push_back(mk(0, 1, 2'b11, 2'b11, 1, 0, 32'h0,        1, 32'h20, 2'b10, 2'b00));
        vecs.push_back(mk(0, 1, 2'b11, 2'b11, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 0, 0, 32'h0,        0, 32'h0,  2'b00, 2'b00));
        // fill ID FIFO, 5th read blocks, write still passes, pop unblocks next cycle
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 32'h0, 1, 32'h10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 32'h0,        0, 32'h0,  2'b00, 2'b00));
        vecs.push_back(mk(0, 1, 2'b11, 2'b10, 1, 0, 32'h0,        1, 32'h20, 2'b10, 2'b00));
        vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 1, 32'hA1,       0, 32'h0,  2'b00, 2'b01));
        vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 32'hB0 + 32'(i), 0, 32'h0, 2'b00, 2'b01));
        // response ordering s0, s1, s0
        vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 1, 2'b10, 2'b00, 1, 0, 32'h0,        1, 32'h20, 2'b10, 2'b00));
        vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 32'hA,        0, 32'h0,  2'b00, 2'b01));
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 32'hB,        0, 32'h0,  2'b00, 2'b10));
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 32'hC,        0, 32'h0,  2'b00, 2'b01));
        // reset with two reads pending; late response dropped, search restarts at s0
        vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));
        vecs.push_back(mk(0, 1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 0, 0, 32'h0,        0, 32'h0,  2'b00, 2'b00));
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 1, 1, 32'hEE,       0, 32'h0,  2'b00, 2'b00));
        vecs.push_back(mk(0, 1, 2'b11, 2'b11, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));
        // clock enable low freezes the pointer
        vecs.push_back(mk(0, 0, 2'b11, 2'b11, 1, 0, 32'h0,        1, 32'h20, 2'b10, 2'b00));
        vecs.push_back(mk(0, 1, 2'b11, 2'b11, 1, 0, 32'h0,        1, 32'h20, 2'b10, 2'b00));
        vecs.push_back(mk(0, 1, 2'b11, 2'b11, 1, 0, 32'h0,        1, 32'h10, 2'b01, 2'b00));

        cke_i = 1'b1; rst_i = 1'b1; s_iob_valid_i = '0; iob_ready_i = 1'b0;
        iob_rvalid_i = 1'b0; iob_rdata_i = '0; s_iob_wstrb_i = '0;
        s_iob_addr_i = {32'h20, 32'h10};
        s_iob_wdata_i = {32'h1001, 32'h1000};

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t r;
            int   k;
            r = vecs[i];
            @(negedge clk_i);
            rst_i         = r.rst;
            cke_i         = r.cke;
            s_iob_valid_i = r.v;
            s_iob_wstrb_i = {(r.wr[1] ? 4'hF : 4'h0), (r.wr[0] ? 4'hF : 4'h0)};
            iob_ready_i   = r.rdy;
            iob_rvalid_i  = r.rv;
            iob_rdata_i   = r.rd;
            #2;
            chk(i, "iob_valid", 32'(iob_valid_o), 32'(r.ev));
            chk(i, "s_ready", 32'(s_iob_ready_o), 32'(r.er));
            chk(i, "s_rvalid", 32'(s_iob_rvalid_o), 32'(r.erv));
            if (r.ev) begin
                k = (r.ea == 32'h20) ? 1 : 0;
                chk(i, "iob_addr", iob_addr_o, r.ea);
                chk(i, "iob_wdata", iob_wdata_o, 32'h1000 + 32'(k));
                chk(i, "iob_wstrb", 32'(iob_wstrb_o), r.wr[k] ? 32'hF : 32'h0);
            end
            if (r.erv != 2'b00) begin
                chk(i, "rdata0", s_iob_rdata_o[31:0], r.rd);
                chk(i, "rdata1", s_iob_rdata_o[63:32], r.rd);
            end
            // scoreboard: response routing follows issue order
            if (s_iob_rvalid_o != 2'b00) begin
                if (sb.size() == 0) begin
                    chk(i, "sb_unexpected_rvalid", 32'(s_iob_rvalid_o), 32'h0);
                end else begin
                    k = sb.pop_front();
                    chk(i, "sb_route", 32'(s_iob_rvalid_o), 32'(1) << k);
                end
            end
            if (r.rst) sb.delete();
            else if (r.cke && r.er != 2'b00 && r.wr[r.er[1]] == 1'b0) sb.push_back(r.er[1] ? 1 : 0);
        end
        chk(vecs.size(), "sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_cache_fe_arbiter.md
# iob_cache_fe_arbiter

Round-robin arbiter that shares a single cache IOb front-end (the `iob_s` port of `iob_cache_axi`) between N_REQ IOb managers, e.g. instruction and data ports of a CPU. Requests are passed through combinationally from the granted manager. A small in-order ID FIFO routes each read response back to the manager that issued the read. The block sits between the managers and the cache front-end, in place of the single testbench converter on the cache's `iob_s` port.

## Interface
- N_REQ, 2, number of requesting managers (≥2); index width IDX_W = $clog2(N_REQ)
- ADDR_W, 32, cache front-end address width
- DATA_W, 32, front-end data width
- PEND_W, 2, log2 of max outstanding reads (ID FIFO depth 2^PEND_W)

Ports:
- clk_i  in  1  clock
- cke_i  in  1  clock enable; all registers hold when low
- rst_i  in  1  reset, synchronous, active-high
- s_iob_valid_i  in  N_REQ  per-manager request valid
- s_iob_addr_i  in  N_REQ*ADDR_W  per-manager address, manager k at slice k
- s_iob_wdata_i  in  N_REQ*DATA_W  per-manager write data
- s_iob_wstrb_i  in  N_REQ*DATA_W/8  per-manager strobe; 0 = read
- s_iob_ready_o  out  N_REQ  per-manager accept
- s_iob_rvalid_o  out  N_REQ  per-manager read response valid
- s_iob_rdata_o  out  N_REQ*DATA_W  read data, broadcast to every slice
- iob_valid_o  out  1  request to cache
- iob_addr_o  out  ADDR_W  muxed address
- iob_wdata_o  out  DATA_W  muxed write data
- iob_wstrb_o  out  DATA_W/8  muxed strobe
- iob_ready_i  in  1  cache accept
- iob_rvalid_i  in  1  cache read response valid
- iob_rdata_i  in  DATA_W  cache read data

## Operation
- State: round-robin pointer `ptr` (IDX_W), lock flag and locked index `lidx`, ID FIFO of 2^PEND_W entries × IDX_W, and occupancy `cnt` (PEND_W+1 bits).
- Grant `g`:
  - If lock=1, g = lidx.
  - Otherwise g = first k with s_iob_valid_i[k]=1, searching ptr, ptr+1, … modulo N_REQ.
  - If no valid and lock=0, there is no grant.
- block = (s_iob_wstrb_i[g]==0) & (cnt==2^PEND_W). Only reads are blocked.
- Outputs:
  - iob_valid_o = s_iob_valid_i[g] & ~block.
  - iob_addr_o, iob_wdata_o and iob_wstrb_o = slice g.
  - s_iob_ready_o[g] = iob_ready_i & ~block; all other ready bits are 0.
- Accept = iob_valid_o & iob_ready_i. On accept:
  - ptr ← (g+1) mod N_REQ.
  - lock ← 0.
  - If the access is a read, push g into the FIFO.
- If iob_valid_o=1 and iob_ready_i=0: lock ← 1 and lidx ← g. Once a request is presented, the grant never moves before its handshake.
- On iob_rvalid_i=1 with cnt>0:
  - Pop the head h.
  - s_iob_rvalid_o[h]=1 in the same cycle.
  - rdata passes through unchanged.
- iob_rvalid_i with cnt==0 is a protocol error: it is dropped, no s_iob_rvalid_o asserts, and cnt stays 0.
- Simultaneous push and pop: allowed when cnt<2^PEND_W, and cnt is unchanged. When cnt is full, reads block even if a pop occurs in the same cycle; the pop frees the slot for the next cycle.
- Writes never enter the FIFO and produce no response.

## Timing
- Request path and response routing are zero-latency combinational. All state updates occur on the rising edge of clk_i when cke_i=1.
- While rst_i=1, the following are forced to 0 regardless of inputs: iob_valid_o, s_iob_ready_o, s_iob_rvalid_o.
- Reset state: ptr=0, lock=0, lidx=0, cnt=0, FIFO read and write pointers = 0.
- Reset mid-operation discards all pending read IDs. Responses that arrive after reset are dropped under the cnt==0 rule.
- Fairness: with all managers continuously valid and iob_ready_i=1, each manager receives exactly one accept every N_REQ cycles.
- The FIFO pointers wrap modulo 2^PEND_W.

## Test plan
- **Single read:** s0 read at 0x10; cache raises ready the same cycle and rvalid 2 cycles later with 0xDEADBEEF. Required: s_iob_ready_o=01 on the request cycle; s_iob_rvalid_o=01 with rdata 0xDEADBEEF; cnt returns to 0.
- **Fairness:** s0 and s1 both valid (writes, wstrb=0xF) for 6 cycles with ready=1. Required: accepts alternate s0,s1,s0,s1,s0,s1 (ptr starts at 0).
- **Lock:** s1 granted with ready=0 for 3 cycles while s0 is also valid. Required: iob_addr_o stays at s1's address; s1 accepted on cycle 4; next grant goes to s0.
- **FIFO full (PEND_W=2):**
  - 4 reads accepted with no rvalid. Required: the 5th read sees ready=0 and iob_valid_o=0.
  - A write from the other manager in the same state. Required: the write is accepted.
  - One rvalid arrives. Required: the blocked read is accepted on the next cycle.
- **Ordering:** reads issued s0, s1, s0, followed by 3 rvalids carrying 0xA, 0xB, 0xC. Required: s_iob_rvalid_o sequence 01, 10, 01 paired with data A, B, C.
- **Reset mid-op:** 2 reads pending, assert rst_i for 1 cycle, then send rvalid. Required: no s_iob_rvalid_o asserts; cnt=0; next grant search starts at s0.
